// File: rtl/enigma_pkg.sv
// Shared Enigma datapath definitions: letter codes, rotor wiring tables, FSM encoding.
package enigma_pkg;

    localparam int unsigned LETTER_W      = 5;
    localparam int unsigned ALPHABET_SIZE = 26;

    typedef logic [LETTER_W-1:0] letter_t;

    localparam letter_t     LAST_CODE = 5'd25;
    localparam logic [5:0]  MOD_W6    = 6'd26;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } state_t;

    // Forward wiring tables, index 0 first (A=0).
    localparam letter_t ROTOR_I [ALPHABET_SIZE] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
    };
    localparam letter_t ROTOR_II [ALPHABET_SIZE] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4
    };
    localparam letter_t ROTOR_III [ALPHABET_SIZE] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14
    };

    function automatic letter_t wiring_entry(input int unsigned rotor_id, input letter_t idx);
        letter_t entry;
        entry = '0;
        if (idx <= LAST_CODE) begin
            case (rotor_id)
                0:       entry = ROTOR_I[idx];
                1:       entry = ROTOR_II[idx];
                2:       entry = ROTOR_III[idx];
                default: entry = '0;
            endcase
        end
        return entry;
    endfunction

endpackage

// File: rtl/rotor_inverse_stage_if.sv
// Valid/ready channel pair for one inverse rotor stage: letter in, mapped letter out.
interface rotor_inverse_stage_if;
    import enigma_pkg::*;

    logic    in_valid;
    logic    in_ready;
    letter_t in_letter;
    letter_t position;
    logic    out_valid;
    logic    out_ready;
    letter_t out_letter;
    logic    out_error;

    modport master (
        output in_valid, in_letter, position, out_ready,
        input  in_ready, out_valid, out_letter, out_error
    );

    modport slave (
        input  in_valid, in_letter, position, out_ready,
        output in_ready, out_valid, out_letter, out_error
    );

endinterface

// File: rtl/mod26_add_sub.sv
// Combinational mod-26 add or subtract of two in-range letter codes.
module mod26_add_sub
    import enigma_pkg::*;
(
    input  letter_t i_a,
    input  letter_t i_b,
    input  logic    i_add,
    output letter_t o_result
);

    logic [5:0] w_a;
    logic [5:0] w_b;
    logic [5:0] w_sum;
    logic [5:0] w_diff;
    logic [5:0] w_res;

    assign w_a    = {1'b0, i_a};
    assign w_b    = {1'b0, i_b};
    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;

    always_comb begin
        w_res = '0;
        if (i_add) begin
            w_res = (w_sum >= MOD_W6) ? (w_sum - MOD_W6) : w_sum;
        end else begin
            // Wraps modulo 64 first; adding 26 lands back in 0..25.
            w_res = (w_a < w_b) ? (w_diff + MOD_W6) : w_diff;
        end
    end

    assign o_result = w_res[4:0];

endmodule

// File: rtl/rotor_inverse_stage.sv
// Inverse rotor mapping: sequential search of the forward wiring table, then offset removal.
module rotor_inverse_stage
    import enigma_pkg::*;
#(
    parameter int unsigned ROTOR_ID = 0
) (
    input logic                  clk,
    input logic                  reset,
    rotor_inverse_stage_if.slave bus
);

    if (ROTOR_ID > 2) begin : g_bad_rotor
        $error("rotor_inverse_stage: ROTOR_ID must be 0, 1 or 2");
    end

    state_t  r_state;
    state_t  w_state_next;
    letter_t r_letter;
    letter_t r_pos;
    letter_t r_target;
    letter_t r_idx;
    letter_t r_out_letter;
    logic    r_out_error;

    letter_t w_target;
    letter_t w_x;
    logic    w_in_illegal;
    logic    w_match;

    mod26_add_sub u_target (
        .i_a      (bus.in_letter),
        .i_b      (bus.position),
        .i_add    (1'b1),
        .o_result (w_target)
    );

    mod26_add_sub u_unoffset (
        .i_a      (r_idx),
        .i_b      (r_pos),
        .i_add    (1'b0),
        .o_result (w_x)
    );

    assign w_in_illegal = (bus.in_letter > LAST_CODE) || (bus.position > LAST_CODE);
    assign w_match      = (wiring_entry(ROTOR_ID, r_idx) == r_target);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) w_state_next = w_in_illegal ? StDone : StSearch;
            end
            StSearch: begin
                if (w_match || (r_idx == LAST_CODE)) w_state_next = StDone;
            end
            StDone: begin
                if (bus.out_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_letter     <= '0;
            r_pos        <= '0;
            r_target     <= '0;
            r_idx        <= '0;
            r_out_letter <= '0;
            r_out_error  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_letter <= bus.in_letter;
                        r_pos    <= bus.position;
                        if (w_in_illegal) begin
                            r_out_letter <= bus.in_letter;
                            r_out_error  <= 1'b1;
                        end else begin
                            r_target <= w_target;
                            r_idx    <= '0;
                        end
                    end
                end
                StSearch: begin
                    if (w_match) begin
                        r_out_letter <= w_x;
                        r_out_error  <= 1'b0;
                    end else if (r_idx < LAST_CODE) begin
                        r_idx <= r_idx + 5'd1;
                    end else begin
                        // Table has no entry for the target: report the input unchanged.
                        r_out_letter <= r_letter;
                        r_out_error  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready   = (r_state == StIdle);
        bus.out_valid  = (r_state == StDone);
        bus.out_letter = r_out_letter;
        bus.out_error  = r_out_error;
    end

endmodule
